// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and access-size constants for the data memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FORCE = 2'd1,
    ACK   = 2'd2
  } state_e;
  localparam logic [2:0] ST_SW = 3'b100;
  localparam logic [2:0] ST_SH = 3'b010;
  localparam logic [2:0] ST_SB = 3'b001;
  localparam logic [4:0] LD_LW = 5'b10000;
  localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the core (priority) and an external word master
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_memwrite,
  input  logic [2:0]        core_st,
  input  logic [4:0]        core_ld,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memwrite,
  output logic [2:0]        mem_st,
  output logic [4:0]        mem_ld,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              ext_ack_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic              core_active;
  logic              ext_sel;
  assign core_active = core_memwrite | (|core_ld);
  assign ext_ack     = ext_ack_q;
  assign ext_rdata   = ext_rdata_q;
  // Arbitration FSM: idle-cycle grants, starvation counting, forced slot and one-cycle ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      ext_ack_q   <= 1'b0;
      ext_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ext_req && !core_active) begin
            ext_rdata_q <= mem_rdata;
            wait_cnt_q  <= '0;
            ext_ack_q   <= 1'b1;
            state_q     <= ACK;
          end else if (ext_req) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_q <= FORCE;
          end else begin
            wait_cnt_q <= '0;
          end
        end
        FORCE: begin
          wait_cnt_q <= '0;
          if (ext_req) begin
            ext_rdata_q <= mem_rdata;
            ext_ack_q   <= 1'b1;
            state_q     <= ACK;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          ext_ack_q  <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
  // Memory-side mux: the external master owns the port only on a granted slot; writes are gated by reset
  always_comb begin
    ext_sel      = ext_req && (state_q == FORCE || (state_q == IDLE && !core_active));
    mem_addr     = ext_sel ? (ext_addr & ~ADDR_W'(3)) : core_addr;
    mem_wdata    = ext_sel ? ext_wdata : core_wdata;
    mem_memwrite = !reset && (ext_sel ? ext_we : core_memwrite);
    mem_st       = ext_sel ? (ext_we ? ST_SW : 3'b000) : core_st;
    mem_ld       = ext_sel ? (ext_we ? 5'b00000 : LD_LW) : core_ld;
    core_stall   = !reset && state_q == FORCE;
    core_rdata   = mem_rdata;
  end
endmodule
